video_pattern_tx: RTL and testbench

VIDEO_PATTERN_TX -- requirements
Module: video_pattern_tx

---
 rtl/video_pattern_tx.sv | 172 +++++++++++++++++
 tb/tb_video_pattern_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_tx.sv
// Video timing and test-pattern source; all outputs registered 1 cycle after the h/v counters, no backpressure (free-running at pixel rate).
// Optional colour-bar pattern is built only when VIDEO_PATTERN_TX_COLORBAR_EN is defined; otherwise pattern 2 is black.
module video_pattern_tx #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic [23:0] vid_data,
  output logic        vid_hs,
  output logic        vid_vs,
  output logic        vid_de,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Ramp and checker read h_cnt[7:0] and v_cnt[3], so keep the counters at least that wide.
  localparam int HW = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
  localparam int VW = ($clog2(V_TOTAL) > 4) ? $clog2(V_TOTAL) : 4;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DE_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DE_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic [1:0]    pat_q, pat_cur;
  logic [23:0]   pix;
  logic          run, first_px, last_px;
  logic          raw_de, raw_hs, raw_vs;

  assign run      = (state == RUN);
  assign first_px = run && (h_cnt == '0) && (v_cnt == '0);
  assign last_px  = run && (h_cnt == H_LAST) && (v_cnt == V_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Counters sit at (0,0) outside RUN so the first RUN cycle is always pixel (0,0).
  always_comb begin
    state_nxt = state;
    h_nxt     = '0;
    v_nxt     = '0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (last_px) begin
          if (!enable) state_nxt = IDLE;
        end else if (h_cnt == H_LAST) begin
          v_nxt = v_cnt + VW'(1);
        end else begin
          h_nxt = h_cnt + HW'(1);
          v_nxt = v_cnt;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign raw_de = (h_cnt < H_DE_END) && (v_cnt < V_DE_END);
  assign raw_hs = (h_cnt >= H_HS_BEG) && (h_cnt < H_HS_END);
  assign raw_vs = (v_cnt >= V_VS_BEG) && (v_cnt < V_VS_END);

  // Pixel (0,0) must already use the newly sampled select, hence the bypass.
  assign pat_cur = first_px ? pattern_sel : pat_q;

`ifdef VIDEO_PATTERN_TX_COLORBAR_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int PW    = ($clog2(BAR_W) > 0) ? $clog2(BAR_W) : 1;
  localparam logic [PW-1:0] BAR_LAST = PW'(BAR_W - 1);

  logic [PW-1:0] bar_px;
  logic [2:0]    bar_idx;
  logic [23:0]   bar_rgb;

  // Tracks the bar of h_nxt so it lines up with h_cnt on the following cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in || (h_nxt == '0)) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (bar_px == BAR_LAST) begin
      bar_px <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_px <= bar_px + PW'(1);
    end
  end

  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end
`endif

  always_comb begin
    pix = 24'h000000;
    case (pat_cur)
      2'd0: pix = {3{h_cnt[7:0]}};
      2'd1: pix = (h_cnt[3] ^ v_cnt[3]) ? 24'hFFFFFF : 24'h000000;
`ifdef VIDEO_PATTERN_TX_COLORBAR_EN
      2'd2: pix = bar_rgb;
`else
      2'd2: pix = 24'h000000;
`endif
      default: pix = 24'hFFFFFF;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vid_data    <= 24'h000000;
      vid_de      <= 1'b0;
      vid_hs      <= ~HS_POL;
      vid_vs      <= ~VS_POL;
      frame_start <= 1'b0;
      frame_cnt   <= 16'h0000;
      busy        <= 1'b0;
      pat_q       <= 2'd0;
    end else begin
      busy        <= run;
      frame_start <= first_px;
      vid_de      <= run && raw_de;
      vid_data    <= (run && raw_de) ? pix : 24'h000000;
      vid_hs      <= (run && raw_hs) ? HS_POL : ~HS_POL;
      vid_vs      <= (run && raw_vs) ? VS_POL : ~VS_POL;
      if (first_px) pat_q <= pattern_sel;
      if (last_px) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_video_pattern_tx.sv
// Directed bench for video_pattern_tx with a 24x8 (192-pixel) frame.
module tb_video_pattern_tx;

  localparam int FRAME = 192;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [23:0] vid_data;
  logic        vid_hs, vid_vs, vid_de, frame_start, busy;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  video_pattern_tx #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable(enable), .pattern_sel(pattern_sel),
    .vid_data(vid_data), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
    .frame_start(frame_start), .frame_cnt(frame_cnt), .busy(busy)
  );

  typedef struct {
    int          pat;
    int          cyc;
    logic [23:0] data;
    logic        de;
    logic        hs;
    logic        vs;
  } vec_t;

  vec_t vecs[$];

  logic [23:0] c_data[FRAME];
  logic        c_de[FRAME], c_hs[FRAME], c_vs[FRAME], c_fs[FRAME], c_busy[FRAME];
  logic [15:0] c_fc[FRAME];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int pat, input int cyc, input logic [23:0] d,
                     input logic de, input logic hs, input logic vs);
    vec_t v;
    v.pat = pat; v.cyc = cyc; v.data = d; v.de = de; v.hs = hs; v.vs = vs;
    vecs.push_back(v);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, 32'(vid_data), 0);
    chk({tag, "_de"}, 32'(vid_de), 0);
    chk({tag, "_hs"}, 32'(vid_hs), 0);
    chk({tag, "_vs"}, 32'(vid_vs), 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_fcnt"}, 32'(frame_cnt), 0);
  endtask

  // Entered at the negedge showing pixel 0; leaves at the negedge after pixel 191.
  task automatic cap_frame(input int chg_at, input logic [1:0] sel, input int drop_at);
    for (int p = 0; p < FRAME; p++) begin
      c_data[p] = vid_data; c_de[p] = vid_de; c_hs[p] = vid_hs; c_vs[p] = vid_vs;
      c_fs[p] = frame_start; c_busy[p] = busy; c_fc[p] = frame_cnt;
      if (p == chg_at) pattern_sel = sel;
      if (p == drop_at) enable = 1'b0;
      @(negedge clk_in);
    end
  endtask

  task automatic check_frame(input int pat, input int k);
    int n_de = 0, n_hs = 0, n_vs = 0, n_fs = 0, n_busy = 0, n_blank = 0, n_act = 0;
    for (int p = 0; p < FRAME; p++) begin
      if (c_de[p]) n_de++;
      if (c_hs[p]) n_hs++;
      if (c_vs[p]) n_vs++;
      if (c_fs[p]) n_fs++;
      if (c_busy[p]) n_busy++;
      if (!c_de[p] && c_data[p] != 24'h0) n_blank++;
      if (pat == 3 && c_de[p] && c_data[p] != 24'hFFFFFF) n_act++;
`ifndef VIDEO_PATTERN_TX_COLORBAR_EN
      if (pat == 2 && c_de[p] && c_data[p] != 24'h0) n_act++;
`endif
    end
    chk($sformatf("pat%0d_de_count", pat), n_de, 64);
    chk($sformatf("pat%0d_hs_count", pat), n_hs, 24);
    chk($sformatf("pat%0d_vs_count", pat), n_vs, 48);
    chk($sformatf("pat%0d_fs_count", pat), n_fs, 1);
    chk($sformatf("pat%0d_fs_at0", pat), 32'(c_fs[0]), 1);
    chk($sformatf("pat%0d_busy_count", pat), n_busy, FRAME);
    chk($sformatf("pat%0d_blank_nonzero", pat), n_blank, 0);
    chk($sformatf("pat%0d_active_bad", pat), n_act, 0);
    chk($sformatf("pat%0d_fcnt_p0", pat), 32'(c_fc[0]), k);
    chk($sformatf("pat%0d_fcnt_p190", pat), 32'(c_fc[190]), k);
    chk($sformatf("pat%0d_fcnt_p191", pat), 32'(c_fc[191]), (k + 1) % 65536);
    foreach (vecs[i]) begin
      if (vecs[i].pat == pat) begin
        chk($sformatf("p%0d_pat%0d_data", vecs[i].cyc, pat), 32'(c_data[vecs[i].cyc]), 32'(vecs[i].data));
        chk($sformatf("p%0d_pat%0d_de", vecs[i].cyc, pat), 32'(c_de[vecs[i].cyc]), 32'(vecs[i].de));
        chk($sformatf("p%0d_pat%0d_hs", vecs[i].cyc, pat), 32'(c_hs[vecs[i].cyc]), 32'(vecs[i].hs));
        chk($sformatf("p%0d_pat%0d_vs", vecs[i].cyc, pat), 32'(c_vs[vecs[i].cyc]), 32'(vecs[i].vs));
      end
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  initial begin
    int idle_err;
    bit found;

    // Pixel index p = line*24 + h of the output stream.
    add(0,   0, 24'h000000, 1, 0, 0);
    add(0,   5, 24'h050505, 1, 0, 0);
    add(0,  15, 24'h0F0F0F, 1, 0, 0);
    add(0,  16, 24'h000000, 0, 0, 0);
    add(0,  17, 24'h000000, 0, 0, 0);
    add(0,  18, 24'h000000, 0, 1, 0);
    add(0,  20, 24'h000000, 0, 1, 0);
    add(0,  21, 24'h000000, 0, 0, 0);
    add(0,  29, 24'h050505, 1, 0, 0);
    add(0,  87, 24'h0F0F0F, 1, 0, 0);
    add(0,  96, 24'h000000, 0, 0, 0);
    add(0, 120, 24'h000000, 0, 0, 1);
    add(0, 138, 24'h000000, 0, 1, 1);
    add(0, 167, 24'h000000, 0, 0, 1);
    add(0, 168, 24'h000000, 0, 0, 0);
    add(0, 191, 24'h000000, 0, 0, 0);
    add(1,   7, 24'h000000, 1, 0, 0);
    add(1,   8, 24'hFFFFFF, 1, 0, 0);
    add(1,  15, 24'hFFFFFF, 1, 0, 0);
    add(1,  56, 24'hFFFFFF, 1, 0, 0);
    add(1,  79, 24'h000000, 1, 0, 0);
    add(1,  87, 24'hFFFFFF, 1, 0, 0);
    add(3,   0, 24'hFFFFFF, 1, 0, 0);
    add(3,  79, 24'hFFFFFF, 1, 0, 0);
    add(3,  16, 24'h000000, 0, 0, 0);
`ifdef VIDEO_PATTERN_TX_COLORBAR_EN
    add(2,   0, 24'hFFFFFF, 1, 0, 0);
    add(2,   1, 24'hFFFFFF, 1, 0, 0);
    add(2,   2, 24'hFFFF00, 1, 0, 0);
    add(2,   3, 24'hFFFF00, 1, 0, 0);
    add(2,   4, 24'h00FFFF, 1, 0, 0);
    add(2,   6, 24'h00FF00, 1, 0, 0);
    add(2,   8, 24'hFF00FF, 1, 0, 0);
    add(2,  10, 24'hFF0000, 1, 0, 0);
    add(2,  12, 24'h0000FF, 1, 0, 0);
    add(2,  15, 24'h000000, 1, 0, 0);
    add(2,  26, 24'hFFFF00, 1, 0, 0);
`else
    add(2,   0, 24'h000000, 1, 0, 0);
    add(2,   2, 24'h000000, 1, 0, 0);
    add(2,   8, 24'h000000, 1, 0, 0);
`endif
    add(2,  16, 24'h000000, 0, 0, 0);

    rst_in = 1'b1; enable = 1'b1; pattern_sel = 2'd0;
    repeat (3) @(negedge clk_in);
    chk_reset_vals("reset");

    // First RUN cycle on the edge after release, pixel (0,0) one edge later.
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("start_gap_fs", 32'(frame_start), 0);
    @(negedge clk_in);
    chk("first_run_fs", 32'(frame_start), 1);
    if (frame_start !== 1'b1) begin
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge clk_in);
        if (frame_start === 1'b1) found = 1;
      end
      if (!found) begin
        bad++;
        $display("FAIL frame_start_timeout: got none expected pulse");
        finish_run();
      end
    end

    cap_frame(30, 2'd1, -1);
    check_frame(0, 0);
    chk("period_a", 32'(frame_start), 1);
    cap_frame(50, 2'd3, -1);
    check_frame(1, 1);
    chk("period_b", 32'(frame_start), 1);
    cap_frame(10, 2'd2, -1);
    check_frame(3, 2);
    chk("period_c", 32'(frame_start), 1);
    cap_frame(10, 2'd0, -1);
    check_frame(2, 3);
    chk("period_d", 32'(frame_start), 1);
    cap_frame(-1, 2'd0, 50);
    check_frame(0, 4);

    idle_err = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0 || vid_de !== 1'b0 || vid_data !== 24'h0 || vid_hs !== 1'b0 ||
          vid_vs !== 1'b0 || frame_start !== 1'b0 || frame_cnt !== 16'd5) idle_err++;
      @(negedge clk_in);
    end
    chk("idle_after_stop", idle_err, 0);

    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_in);
      if (frame_start === 1'b1) found = 1;
    end
    chk("restart_found", 32'(found), 1);
    chk("restart_fcnt", 32'(frame_cnt), 5);
    repeat (100) @(negedge clk_in);
    chk("midframe_busy", 32'(busy), 1);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk_reset_vals("midrst");
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("midrst_gap_fs", 32'(frame_start), 0);
    @(negedge clk_in);
    chk("midrst_first_fs", 32'(frame_start), 1);
    cap_frame(-1, 2'd0, -1);
    check_frame(0, 0);

    finish_run();
  end

endmodule
